// File: rtl/id_ex_reg_if.sv
// ID/EX pipeline register bus: decoded fields from ID, registered fields to EX,
// plus the stall/flush controls and the load-use hazard / bubble counter outputs.
interface id_ex_reg_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            flush;

    logic            ID_valid;
    logic            ID_RegWrite, ID_MemWrite, ID_MemRead, ID_ALUSrc;
    logic [2:0]      ID_WDSel, ID_DMType, ID_NPCOp;
    logic [4:0]      ID_ALUOp;
    logic [XLEN-1:0] ID_PC, ID_RD1, ID_RD2, ID_imm;
    logic [4:0]      ID_rd, ID_rs1, ID_rs2;

    logic            EX_valid;
    logic            EX_RegWrite, EX_MemWrite, EX_MemRead, EX_ALUSrc;
    logic [2:0]      EX_WDSel, EX_DMType, EX_NPCOp;
    logic [4:0]      EX_ALUOp;
    logic [XLEN-1:0] EX_PC, EX_RD1, EX_RD2, EX_imm;
    logic [4:0]      EX_rd, EX_rs1, EX_rs2;

    logic            load_use_hazard;
    logic [31:0]     bubble_cnt;

    modport master (
        output stall, flush, ID_valid,
               ID_RegWrite, ID_MemWrite, ID_MemRead, ID_ALUSrc,
               ID_WDSel, ID_DMType, ID_NPCOp, ID_ALUOp,
               ID_PC, ID_RD1, ID_RD2, ID_imm, ID_rd, ID_rs1, ID_rs2,
        input  EX_valid,
               EX_RegWrite, EX_MemWrite, EX_MemRead, EX_ALUSrc,
               EX_WDSel, EX_DMType, EX_NPCOp, EX_ALUOp,
               EX_PC, EX_RD1, EX_RD2, EX_imm, EX_rd, EX_rs1, EX_rs2,
               load_use_hazard, bubble_cnt
    );

    modport slave (
        input  stall, flush, ID_valid,
               ID_RegWrite, ID_MemWrite, ID_MemRead, ID_ALUSrc,
               ID_WDSel, ID_DMType, ID_NPCOp, ID_ALUOp,
               ID_PC, ID_RD1, ID_RD2, ID_imm, ID_rd, ID_rs1, ID_rs2,
        output EX_valid,
               EX_RegWrite, EX_MemWrite, EX_MemRead, EX_ALUSrc,
               EX_WDSel, EX_DMType, EX_NPCOp, EX_ALUOp,
               EX_PC, EX_RD1, EX_RD2, EX_imm, EX_rd, EX_rs1, EX_rs2,
               load_use_hazard, bubble_cnt
    );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/stall, load-use hazard detect.
// Define ID_EX_PERF_CNT_EN to build in the saturating bubble counter.
module id_ex_reg #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_reg_if.slave   bus
);
    typedef struct packed {
        logic       RegWrite;
        logic       MemWrite;
        logic       MemRead;
        logic       ALUSrc;
        logic [2:0] WDSel;
        logic [2:0] DMType;
        logic [2:0] NPCOp;
        logic [4:0] ALUOp;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] RD1;
        logic [XLEN-1:0] RD2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
    } data_t;

    ctrl_t id_ctrl, ex_ctrl;
    data_t id_data, ex_data;
    logic  ex_valid;

    assign id_ctrl = '{RegWrite: bus.ID_RegWrite, MemWrite: bus.ID_MemWrite,
                       MemRead: bus.ID_MemRead, ALUSrc: bus.ID_ALUSrc,
                       WDSel: bus.ID_WDSel, DMType: bus.ID_DMType,
                       NPCOp: bus.ID_NPCOp, ALUOp: bus.ID_ALUOp};
    assign id_data = '{PC: bus.ID_PC, RD1: bus.ID_RD1, RD2: bus.ID_RD2,
                       imm: bus.ID_imm, rd: bus.ID_rd, rs1: bus.ID_rs1,
                       rs2: bus.ID_rs2};

    // An invalid decode slot still carries its data, but its control is
    // zeroed so it can never write architectural state downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_data  <= '0;
        end else if (bus.flush) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_data  <= '0;
        end else if (!bus.stall) begin
            ex_valid <= bus.ID_valid;
            ex_ctrl  <= bus.ID_valid ? id_ctrl : '0;
            ex_data  <= id_data;
        end
    end

    assign bus.EX_valid    = ex_valid;
    assign bus.EX_RegWrite = ex_ctrl.RegWrite;
    assign bus.EX_MemWrite = ex_ctrl.MemWrite;
    assign bus.EX_MemRead  = ex_ctrl.MemRead;
    assign bus.EX_ALUSrc   = ex_ctrl.ALUSrc;
    assign bus.EX_WDSel    = ex_ctrl.WDSel;
    assign bus.EX_DMType   = ex_ctrl.DMType;
    assign bus.EX_NPCOp    = ex_ctrl.NPCOp;
    assign bus.EX_ALUOp    = ex_ctrl.ALUOp;
    assign bus.EX_PC       = ex_data.PC;
    assign bus.EX_RD1      = ex_data.RD1;
    assign bus.EX_RD2      = ex_data.RD2;
    assign bus.EX_imm      = ex_data.imm;
    assign bus.EX_rd       = ex_data.rd;
    assign bus.EX_rs1      = ex_data.rs1;
    assign bus.EX_rs2      = ex_data.rs2;

    // Deliberately not gated by stall/flush; the fetch/decode side arbitrates.
    assign bus.load_use_hazard = ex_valid && ex_ctrl.MemRead && (ex_data.rd != 5'd0) &&
                                 bus.ID_valid &&
                                 ((ex_data.rd == bus.ID_rs1) || (ex_data.rd == bus.ID_rs2));

`ifdef ID_EX_PERF_CNT_EN
    logic        bubble_load;
    logic [31:0] bubble_q;

    assign bubble_load = bus.flush || (!bus.stall && !bus.ID_valid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bubble_q <= '0;
        else if (bubble_load && (bubble_q != 32'hFFFF_FFFF))
            bubble_q <= bubble_q + 32'd1;
    end

    assign bus.bubble_cnt = bubble_q;
`else
    assign bus.bubble_cnt = '0;
`endif
endmodule
